// File: rtl/hwpe_ctrl_offloader_if.sv
// Peripheral register bus between the offloader (master) and an HWPE control slave.
interface hwpe_ctrl_offloader_if #(
  parameter int unsigned ID_WIDTH = 8
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/hwpe_ctrl_offloader.sv
// HWPE control offloader: acquires a context, writes job registers, triggers,
// then waits for the accelerator done event before reporting completion.
module hwpe_ctrl_offloader #(
  parameter int unsigned         N_JOB_REGS = 48,
  parameter int unsigned         ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] PERIPH_ID  = '0,
  parameter int unsigned         RETRY_WAIT = 16,
  parameter logic [31:0]         BASE_ADDR  = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [5:0]              job_nb_regs_i,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  output logic                    done_o,
  output logic [2:0]              done_ctx_o,
  output logic                    busy_o,
  input  logic                    evt_i,
  hwpe_ctrl_offloader_if.master   periph
);

  typedef enum logic [3:0] {
    IDLE, ACQ_REQ, ACQ_RSP, BACKOFF, WR_REQ, WR_RSP,
    TRIG_REQ, TRIG_RSP, WAIT_EVT, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [N_JOB_REGS*32-1:0] regs_q;
  logic [5:0]              nb_q;
  logic [5:0]              k_q;
  logic [2:0]              ctx_q;
  logic [31:0]             bo_cnt_q;
  logic                    evt_seen_q;
  logic                    job_ready_q;
  logic                    rsp_ok;
  logic                    hs;
  logic [31:0]             wr_data;
  logic                    unused_rdata;

  assign rsp_ok       = periph.r_valid && (periph.r_id == PERIPH_ID);
  assign hs           = job_valid_i && job_ready_q;
  assign unused_rdata = ^periph.r_data[30:3];

  // State register and job datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      job_ready_q <= 1'b0;
      regs_q      <= '0;
      nb_q        <= '0;
      k_q         <= '0;
      ctx_q       <= '0;
      bo_cnt_q    <= '0;
      evt_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_ready_q <= (state_d == IDLE);
      if (hs) begin
        regs_q <= job_regs_i;
        nb_q   <= (job_nb_regs_i > 6'(N_JOB_REGS)) ? 6'(N_JOB_REGS) : job_nb_regs_i;
      end
      if (state_q == ACQ_RSP && rsp_ok && !periph.r_data[31])
        ctx_q <= periph.r_data[2:0];
      if (state_q == ACQ_RSP)
        k_q <= '0;
      else if (state_q == WR_RSP && rsp_ok)
        k_q <= k_q + 6'd1;
      if (state_q == BACKOFF)
        bo_cnt_q <= bo_cnt_q + 32'd1;
      else
        bo_cnt_q <= '0;
      // sticky event window opens at the trigger grant, so an early evt is not lost
      if (state_d == TRIG_REQ && state_q != TRIG_REQ)
        evt_seen_q <= 1'b0;
      else if (evt_i && ((state_q == TRIG_REQ && periph.gnt) ||
                         state_q == TRIG_RSP || state_q == WAIT_EVT))
        evt_seen_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (hs) state_d = ACQ_REQ;
      ACQ_REQ:  if (periph.gnt) state_d = ACQ_RSP;
      ACQ_RSP:
        if (rsp_ok) begin
          if (periph.r_data[31])  state_d = BACKOFF;
          else if (nb_q != 6'd0)  state_d = WR_REQ;
          else                    state_d = TRIG_REQ;
        end
      BACKOFF:  if (bo_cnt_q == RETRY_WAIT - 1) state_d = ACQ_REQ;
      WR_REQ:   if (periph.gnt) state_d = WR_RSP;
      WR_RSP:
        if (rsp_ok) state_d = (k_q == nb_q - 6'd1) ? TRIG_REQ : WR_REQ;
      TRIG_REQ: if (periph.gnt) state_d = TRIG_RSP;
      TRIG_RSP: if (rsp_ok) state_d = WAIT_EVT;
      WAIT_EVT: if (evt_seen_q || evt_i) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < N_JOB_REGS; i++)
      if (k_q == 6'(i)) wr_data = regs_q[32*i +: 32];

    periph.req  = 1'b0;
    periph.add  = '0;
    periph.wen  = 1'b0;
    periph.be   = 4'hF;
    periph.data = '0;
    periph.id   = PERIPH_ID;
    done_o      = 1'b0;
    done_ctx_o  = '0;
    busy_o      = (state_q != IDLE);
    job_ready_o = job_ready_q;
    case (state_q)
      ACQ_REQ: begin
        periph.req = 1'b1;
        periph.wen = 1'b1;
        periph.add = BASE_ADDR + 32'h4;
      end
      WR_REQ: begin
        periph.req  = 1'b1;
        periph.add  = BASE_ADDR + 32'h20 + {24'b0, k_q, 2'b00};
        periph.data = wr_data;
      end
      TRIG_REQ: begin
        periph.req = 1'b1;
        periph.add = BASE_ADDR;
      end
      DONE: begin
        done_o     = 1'b1;
        done_ctx_o = ctx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/hwpe_ctrl_offloader.md
Name: hwpe_ctrl_offloader

Overview:
- Initiator-side counterpart of the HWPE control slave: drives the peripheral register bus into an accelerator's control regfile on behalf of a local controller.
- Per job: acquires a context, writes the job's IO registers, triggers, then waits for the done event.
- Sits between a core-side job source (valid/ready) and the HWPE peripheral slave port.

Parameters:
- N_JOB_REGS, 48, maximum job registers per job; must be at most REGFILE_N_MAX_IO_REGS (48).
- ID_WIDTH, 8, width of the peripheral transaction ID.
- PERIPH_ID, 0, constant ID driven on every request. Responses carrying any other ID are ignored.
- RETRY_WAIT, 16, backoff cycles after a failed acquire (≥1).
- BASE_ADDR, 32'h0, byte base address of the HWPE register window.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  offloader can accept a job.
- job_nb_regs_i  in  6  number of job registers to write.
- job_regs_i  in  N_JOB_REGS*32  job register values; entry i occupies bits [32i+31:32i].
- done_o  out  1  one-cycle pulse when the job has completed.
- done_ctx_o  out  3  context ID of the completed job; valid while done_o is high.
- busy_o  out  1  high in every state except IDLE.
- evt_i  in  1  HWPE done event, a single-cycle pulse.
- periph_req_o  out  1  request.
- periph_gnt_i  in  1  grant.
- periph_add_o  out  32  byte address.
- periph_wen_o  out  1  1 = read, 0 = write.
- periph_be_o  out  4  byte enables; always 4'hF.
- periph_data_o  out  32  write data.
- periph_id_o  out  ID_WIDTH  transaction ID; always PERIPH_ID.
- periph_r_valid_i  in  1  response valid.
- periph_r_data_i  in  32  read data.
- periph_r_id_i  in  ID_WIDTH  response ID.

Behaviour:
- Reset values (rst_i high at a rising edge): all outputs 0 except periph_be_o = 4'hF and periph_id_o = PERIPH_ID; FSM returns to IDLE.
  - Reset mid-operation abandons any outstanding transaction. req drops on the next edge; no SOFTCLEAR write is issued.
- Register addressing: address = BASE_ADDR + 4*index.
  - ACQUIRE is index 1; TRIGGER is index 0.
  - Job register i is index 8+i (mandatory registers occupy indices 0..7).
- Bus rule: at most one outstanding transaction.
  - req, add, wen and data stay stable from assertion until the cycle in which gnt=1; req deasserts the following cycle.
  - After the grant, wait for r_valid with r_id == PERIPH_ID, at earliest 1 cycle after the grant, for both reads and writes.
- Job handshake: on job_valid_i && job_ready_o, latch job_regs_i and nb = min(job_nb_regs_i, N_JOB_REGS).
  - job_ready_o is high only in IDLE and is registered.
- FSM states and transitions:
  - IDLE: on job handshake -> ACQ_REQ.
  - ACQ_REQ: read ACQUIRE; on gnt -> ACQ_RSP.
  - ACQ_RSP: on response:
    - r_data[31]=1 (no free context, -1) -> BACKOFF.
    - Otherwise latch ctx = r_data[2:0]; go to WR_REQ if nb>0, else TRIG_REQ.
  - BACKOFF: count RETRY_WAIT cycles -> ACQ_REQ. Retries are unbounded.
  - WR_REQ / WR_RSP: write reg[k] at index 8+k for k = 0..nb-1, in ascending order. After the response to k = nb-1 -> TRIG_REQ.
  - TRIG_REQ / TRIG_RSP: write 32'h0 to TRIGGER; on response -> WAIT_EVT.
  - WAIT_EVT: on evt seen -> DONE.
  - DONE: done_o=1 and done_ctx_o=ctx for exactly one cycle -> IDLE.
- Event capture: a sticky evt_seen flag is cleared on TRIG_REQ entry and set by evt_i from the trigger grant cycle onward. An event arriving during TRIG_RSP therefore still completes the job; WAIT_EVT exits in the cycle evt_seen or evt_i is high. evt_i outside this window is ignored.
- Counter k: 6 bits, reset to 0 on WR_REQ entry from ACQ_RSP; no wrap, since it is bounded by nb.
- gnt or r_valid arriving in states not expecting them is ignored.
- Minimum job latency, with nb writes, gnt in the same cycle as req and response 1 cycle after gnt: 2*(nb+2) + 2 cycles from handshake to done_o.

Test Plan:
- Single job: nb=3, regs=0xA,0xB,0xC; ACQUIRE returns 2; zero-wait slave.
  -> reads at 0x04, then writes 0xA@0x20, 0xB@0x24, 0xC@0x28, then 0x0@0x00; after evt_i, done_o pulse with done_ctx_o=2; total 12 cycles.
- ACQUIRE returns 0xFFFFFFFF twice, then 1; RETRY_WAIT=16.
  -> three reads at 0x04, each pair separated by ≥16 idle cycles; done_ctx_o=1.
- nb=0 -> no register writes; TRIGGER write immediately follows the acquire response.
- nb=63 with N_JOB_REGS=48 -> exactly 48 writes, the last at 0x20+4*47 = 0xDC.
- Slave holds gnt low for 5 cycles and returns a response with the wrong r_id before the correct one -> req/add/data stable for all 5 cycles; the wrong-ID response is ignored and the FSM advances only on the matching ID.
- evt_i pulse in the cycle after the trigger grant (before its response) -> done_o still asserts after the trigger response.
- rst_i in WR_RSP -> next cycle all outputs at reset values; a new job completes normally.
